branch_ctrl: RTL
================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter FLUSH_LEN, default 2, SHALL set the number of cycles flush is held after a redirect handshake; legal range 1..15.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of taken_count.
REQ-003 clk  in  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be a synchronous, active-low reset sampled on clk.
REQ-005 in_valid  in  1  branch/jump op offered; in_ready  out  1  block can accept.
REQ-006 in_pc, in_imm, in_rs1, in_rs2  in  32 each  op PC, sign-extended immediate, source operands.
REQ-007 in_funct3  in  3  branch condition code; in_kind  in  2  00 branch, 01 jal, 10 jalr, 11 reserved.
REQ-008 cmp_a, cmp_b  out  32; cmp_funct3  out  3  operands/condition driven to the external branch comparator.
REQ-009 cmp_taken  in  1  combinational comparator result for cmp_a/cmp_b/cmp_funct3.
REQ-010 redir_valid  out  1; redir_ready  in  1; redir_pc  out  32  redirect request to fetch.
REQ-011 flush  out  1  squash younger pipeline stages.
REQ-012 link_valid  out  1; link_data  out  32  jal/jalr return address (pc+4) for writeback.
REQ-013 taken_count  out  CNT_W  number of taken control transfers; busy  out  1  state != IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EVAL, REDIRECT, FLUSH; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: on in_valid & in_ready, capture pc/imm/rs1/rs2/funct3/kind into registers and go to EVAL; otherwise stay.
REQ-016 EVAL (exactly 1 cycle): cmp_a/cmp_b/cmp_funct3 driven from captured registers; in all other states cmp_* SHALL hold the last captured values.
REQ-017 Taken decision: kind 00 -> cmp_taken; kind 01/10 -> 1; kind 11 -> 0; funct3 010/011 on kind 00 -> 0 regardless of cmp_taken.
REQ-018 Target: kind 00/01 -> pc+imm; kind 10 -> (rs1+imm) with bit 0 cleared; addition modulo 2^32, wrap-around silently.
REQ-019 EVAL exit: taken -> REDIRECT with redir_pc registered; not taken -> IDLE.
REQ-020 For kind 01/10, link_valid SHALL pulse 1 cycle in the cycle after EVAL with link_data = pc+4 (mod 2^32); link_data holds otherwise; link_valid 0 for kinds 00/11.
REQ-021 REDIRECT: redir_valid=1, redir_pc stable until redir_ready sampled 1; then go to FLUSH; unbounded wait if redir_ready stays 0.
REQ-022 FLUSH: flush=1 for exactly FLUSH_LEN cycles, then IDLE; flush=0 in all other states.
REQ-023 taken_count SHALL increment by 1 at each EVAL with taken=1, saturating at 2^CNT_W-1.
REQ-024 Latency: accept at edge N -> EVAL cycle N+1 -> redir_valid earliest N+2; not-taken op -> in_ready high at N+2.
REQ-025 in_* inputs outside the accept cycle SHALL have no effect.

Reset
REQ-026 On rst_n=0 at an edge, from any state including mid-REDIRECT/FLUSH: state=IDLE, redir_valid=0, flush=0, link_valid=0, taken_count=0, redir_pc=0, link_data=0, cmp_*=0, busy=0; pending redirect is dropped.
REQ-027 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.

Verification
REQ-028 BEQ rs1=rs2=5, pc=0x100, imm=0x20, redir_ready=1 -> redir_valid at N+2 with redir_pc=0x120, flush 2 cycles, taken_count=1.
REQ-029 BLT rs1=0xFFFFFFFF, rs2=1 (comparator returns 1) vs BLTU same operands (returns 0) -> first redirects, second returns to IDLE at N+2 with no redir_valid/flush.
REQ-030 JALR pc=0x200, rs1=0x1001, imm=0x2 -> redir_pc=0x1002, link_valid pulse with link_data=0x204.
REQ-031 JAL pc=0xFFFFFFFC, imm=8 with redir_ready held 0 for 5 cycles -> redir_valid and redir_pc=0x4 stable 5 cycles, in_ready=0 throughout, link_data=0x0.
REQ-032 rst_n low during FLUSH cycle 1 -> next cycle flush=0, busy=0, taken_count=0, in_ready=1 after release.
REQ-033 kind 00 with funct3=010 and cmp_taken forced 1 -> not taken, taken_count unchanged.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: branch/jump resolver (in_* op in, cmp_* to external comparator, redir_* to fetch, flush, link_* writeback, taken_count, busy)
module branch_ctrl #(
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [2:0] in_funct3,
  input  logic [1:0] in_kind,
  output logic [31:0] cmp_a,
  output logic [31:0] cmp_b,
  output logic [2:0] cmp_funct3,
  input  logic cmp_taken,
  output logic redir_valid,
  input  logic redir_ready,
  output logic [31:0] redir_pc,
  output logic flush,
  output logic link_valid,
  output logic [31:0] link_data,
  output logic [CNT_W-1:0] taken_count,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} state_t;
  state_t state;
  logic [31:0] op_pc, op_imm;
  logic [1:0] op_kind;
  logic [3:0] flush_left;
  logic taken;
  logic [31:0] target;
  always_comb begin
    taken = op_kind == 2'b00 ? cmp_taken && cmp_funct3[2:1] != 2'b01 : op_kind != 2'b11;
    target = op_kind == 2'b10 ? (cmp_a + op_imm) & ~32'h1 : op_pc + op_imm;
  end
  assign in_ready = rst_n && state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      op_pc <= '0;
      op_imm <= '0;
      op_kind <= '0;
      flush_left <= '0;
      cmp_a <= '0;
      cmp_b <= '0;
      cmp_funct3 <= '0;
      redir_valid <= 1'b0;
      redir_pc <= '0;
      flush <= 1'b0;
      link_valid <= 1'b0;
      link_data <= '0;
      taken_count <= '0;
    end else begin
      link_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          op_pc <= in_pc;
          op_imm <= in_imm;
          op_kind <= in_kind;
          cmp_a <= in_rs1;
          cmp_b <= in_rs2;
          cmp_funct3 <= in_funct3;
          state <= EVAL;
        end
        EVAL: begin
          state <= taken ? REDIRECT : IDLE;
          if (taken) begin
            redir_valid <= 1'b1;
            redir_pc <= target;
            if (taken_count != '1) taken_count <= taken_count + 1'b1;
          end
          if (op_kind == 2'b01 || op_kind == 2'b10) begin
            link_valid <= 1'b1;
            link_data <= op_pc + 32'd4;
          end
        end
        REDIRECT: if (redir_ready) begin
          redir_valid <= 1'b0;
          flush <= 1'b1;
          flush_left <= 4'(FLUSH_LEN - 1);
          state <= FLUSH;
        end
        FLUSH: if (flush_left == '0) begin
          flush <= 1'b0;
          state <= IDLE;
        end else flush_left <= flush_left - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
